mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares one unified single-port memory between the MIPS core's instruction-fetch port and its load/store data port. Each requester uses a req/ack handshake; the block serialises the requests onto one memory transaction interface with a ready handshake. It sits between the core (`pc`/`instr` and `aluout`/`writedata`/`readdata`/`memwrite`) and the memory. Fairness is round-robin; an optional watchdog aborts hung transactions.

## Interface
- `AW`, default 32, address width.
- `DW`, default 32, data width.
- `TIMEOUT_CYCLES`, default 255, busy cycles before abort (watchdog build only); 8-bit counter, legal range 1..255.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `i_req` in 1: instruction fetch request, held until `i_ack`.
- `i_addr` in AW: fetch address (the core's `pc`).
- `i_rdata` out DW: fetched word; valid when `i_ack`=1.
- `i_ack` out 1: one-cycle completion pulse.
- `d_req` in 1: data request, held until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load (the core's `memwrite`).
- `d_addr` in AW: data address (the core's `aluout`).
- `d_wdata` in DW: store data (the core's `writedata`).
- `d_rdata` out DW: load data (the core's `readdata`); valid when `d_ack`=1.
- `d_ack` out 1: one-cycle completion pulse.
- `err` out 1: abort flag; valid with the ack pulse. Tied 0 without the watchdog.
- `mem_req` out 1: memory transaction active.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data; sampled when `mem_ready`=1.
- `mem_ready` in 1: memory completion; may be high in the first `mem_req` cycle.

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP. `last` is a 1-bit register holding the last grant; it resets to I.
- IDLE:
  - `d_req` only -> BUSY_D.
  - `i_req` only -> BUSY_I.
  - Both -> grant the requester that is not `last`, so data wins the first tie after reset.
  - Neither -> stay in IDLE.
- On grant:
  - Register `mem_addr` and `mem_wdata`.
  - Register `mem_we` as `d_we` for a data grant, 0 for a fetch grant.
  - Set `mem_req`=1 and update `last`.
- BUSY_x:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable.
  - When `mem_ready`=1 at an edge: capture `mem_rdata` into `x_rdata`, drop `mem_req` and `mem_we`, go to RESP.
- RESP:
  - Drive the granted requester's ack high for exactly one cycle, then go to IDLE.
  - `x_rdata` holds its value until that requester's next completion.
  - For a store, `d_rdata` is updated with whatever `mem_rdata` shows.
- Requester rule: req and its payload must stay stable from assertion until the ack cycle. In the ack cycle the requester may drop req or present a new request; IDLE samples it on the following cycle.
- The arbiter never samples requests in BUSY or RESP. A request that arrives mid-transaction waits in IDLE order.
- Reset (including mid-transaction):
  - State IDLE; `mem_req`, `mem_we`, `i_ack`, `d_ack`, `err` = 0.
  - `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` = 0; `last` = I.
  - No ack is issued for the aborted transaction.

## Timing
- Latency is counted from a req sampled in IDLE at edge E:
  - `mem_req` high after E.
  - With `mem_ready` in the first busy cycle, ack is high in cycle E+2.
  - Minimum 3 cycles per transaction, including the IDLE cycle.
  - Each extra wait cycle of `mem_ready` adds 1.
- Back-to-back transactions: IDLE, BUSY, RESP repeat. Peak throughput is one transaction per 3 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `ARB_TIMEOUT_EN` defined (watchdog compiled in):
  - An 8-bit counter clears on grant and increments each BUSY cycle without `mem_ready`.
  - If it reaches `TIMEOUT_CYCLES` in BUSY with `mem_ready`=0:
    - Drop `mem_req` and go to RESP.
    - Pulse the ack with `err`=1; `x_rdata` = 0.
  - If `mem_ready` arrives on the timeout cycle itself, completion wins and `err`=0.
- `ARB_TIMEOUT_EN` undefined:
  - No counter; BUSY waits indefinitely.
  - `err` is constant 0.

## Test plan
- Single fetch, `i_addr`=0x0000_0040, `mem_ready` in the first busy cycle, `mem_rdata`=0x2010_0005 -> `mem_addr`=0x40 and `mem_we`=0; `i_ack` high for 1 cycle at E+2 with `i_rdata`=0x2010_0005.
- Store, `d_addr`=0x54, `d_wdata`=0x0000_0007, `mem_ready` delayed 3 cycles -> `mem_we`=1 with address and data stable for 4 busy cycles; `d_ack` at E+5.
- `i_req` and `d_req` both held for 4 transactions after reset -> grant order D, I, D, I; exactly one ack per RESP.
- Reset asserted in BUSY_D -> all outputs 0 asynchronously with no ack; after release, a pending `d_req` is re-granted normally.
- With `ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `mem_ready` never asserted -> `mem_req` drops after 4 busy cycles; ack with `err`=1 and `rdata`=0.
- Without the macro, same stimulus -> `mem_req` stays high for 300 cycles, no ack, `err`=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter_if                                                           |
// | Fetch port, load/store port and memory bus of the two-way arbiter.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          err;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_ack,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack, err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_ack,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack, err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter                                                              |
// | Round-robin fetch/data arbiter onto one single-port memory; the          |
// | ARB_TIMEOUT_EN macro compiles in a watchdog that aborts hung accesses.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          err_q, err_d;
  logic          pick_data;
  logic          timeout;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]    wdog_q, wdog_d;
  // Fires in the busy cycle whose count would reach the limit.
  assign timeout = (({1'b0, wdog_q} + 9'd1) == 9'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif
    // last_q = 1 means data was served last, so a tie then goes to fetch.
    pick_data   = bus.d_req & ~(bus.i_req & last_q);

    case (state_q)
      IDLE: begin
        if (bus.i_req | bus.d_req) begin
          state_d    = pick_data ? BUSY_D : BUSY_I;
          last_d     = pick_data;
          mem_req_d  = 1'b1;
          mem_we_d   = pick_data & bus.d_we;
          mem_addr_d = pick_data ? bus.d_addr : bus.i_addr;
          if (pick_data) begin
            mem_wdata_d = bus.d_wdata;
          end
`ifdef ARB_TIMEOUT_EN
          wdog_d = 8'd0;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready || timeout) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = ~bus.mem_ready;
          if (state_q == BUSY_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wdog_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
`ifdef ARB_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.err       = err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire
